// File: rtl/pw3_channel_collector.sv
// Layer-3 pointwise output channel collector.
// Gathers CH_NUM channel vectors into one double-buffered frame word.
module pw3_channel_collector #(
  parameter int DATA_W  = 8,
  parameter int PIX_NUM = 36,
  parameter int CH_NUM  = 32,
  parameter int CNT_W   = 6
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             frame_start_i,
  input  logic                             pix_valid_i,
  input  logic [PIX_NUM*DATA_W-1:0]        pix_i,
  output logic [CH_NUM*PIX_NUM*DATA_W-1:0] frame_o,
  output logic                             frame_valid_o,
  output logic [CNT_W-1:0]                 ch_cnt_o,
  output logic                             frame_err_o
);

  localparam int VW = PIX_NUM * DATA_W;
  localparam int FW = CH_NUM * VW;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CH_NUM - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] eff_cnt;
  logic             active;
  logic             accept;
  logic             complete;
  logic             store;
  logic             err_set;
  logic [FW-1:0]    full_w;

  // State and channel-count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ch_cnt_o <= '0;
    end else begin
      state_q  <= state_d;
      ch_cnt_o <= cnt_d;
    end
  end

  // Next state: a start rewinds the slot before any same-cycle vector
  always_comb begin
    active   = frame_start_i | (state_q == COLLECT);
    eff_cnt  = frame_start_i ? '0 : ch_cnt_o;
    accept   = pix_valid_i & active;
    complete = accept & (eff_cnt == LAST);
    store    = accept & ~complete;
    state_d  = state_q;
    cnt_d    = ch_cnt_o;
    if (complete) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (active) begin
      state_d = COLLECT;
      cnt_d   = store ? eff_cnt + CNT_W'(1) : eff_cnt;
    end
  end

  // Outputs: stray vectors and truncated frames raise the error
  always_comb begin
    err_set = (pix_valid_i & ~active)
            | (frame_start_i & (state_q == COLLECT)
               & (ch_cnt_o != '0));
  end

  if (CH_NUM > 1) begin : g_col
    logic [(CH_NUM-1)*VW-1:0] col_q;

    // Collect buffer: one slot per leading channel
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        col_q <= '0;
      end else begin
        for (int k = 0; k < CH_NUM - 1; k++) begin
          if (store && eff_cnt == CNT_W'(k))
            col_q[k*VW +: VW] <= pix_i;
        end
      end
    end

    assign full_w = {pix_i, col_q};
  end else begin : g_nocol
    assign full_w = pix_i;
  end

  // Output frame register, pulse and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_o       <= '0;
      frame_valid_o <= 1'b0;
      frame_err_o   <= 1'b0;
    end else begin
      frame_valid_o <= complete;
      if (complete)
        frame_o <= full_w;
      if (err_set)
        frame_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pw3_channel_collector.sv
// Directed bench for pw3_channel_collector.
// Hand-built expected frames, immediate-assert checks.
module tb_pw3_channel_collector;

  localparam int DATA_W  = 8;
  localparam int PIX_NUM = 36;
  localparam int CH_NUM  = 32;
  localparam int CNT_W   = 6;
  localparam int VW      = PIX_NUM * DATA_W;
  localparam int FW      = CH_NUM * VW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             frame_start_i = 1'b0;
  logic             pix_valid_i = 1'b0;
  logic [VW-1:0]    pix_i = '0;
  logic [FW-1:0]    frame_o;
  logic             frame_valid_o;
  logic [CNT_W-1:0] ch_cnt_o;
  logic             frame_err_o;

  int n_cmp = 0;
  int n_err = 0;
  int vcount = 0;
  int dbl = 0;
  logic prev_v = 1'b0;

  logic [7:0]    eb [CH_NUM];
  logic [FW-1:0] exp_f;
  logic [FW-1:0] f1;

  pw3_channel_collector #(
    .DATA_W(DATA_W), .PIX_NUM(PIX_NUM),
    .CH_NUM(CH_NUM), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .frame_start_i(frame_start_i),
    .pix_valid_i(pix_valid_i),
    .pix_i(pix_i),
    .frame_o(frame_o),
    .frame_valid_o(frame_valid_o),
    .ch_cnt_o(ch_cnt_o),
    .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid_o) vcount++;
    if (frame_valid_o && prev_v) dbl++;
    prev_v = frame_valid_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  task automatic chk_frame(input string tag,
                           input logic [FW-1:0] want);
    int idx;
    idx = -1;
    for (int i = FW/8 - 1; i >= 0; i--)
      if (frame_o[i*8 +: 8] !== want[i*8 +: 8]) idx = i;
    n_cmp++;
    assert (frame_o === want) else begin
      n_err++;
      $error("FAIL %s byte %0d got %h want %h",
             tag, idx, frame_o[idx*8 +: 8],
             want[idx*8 +: 8]);
    end
  endtask

  function automatic logic [FW-1:0] build();
    logic [FW-1:0] f;
    for (int k = 0; k < CH_NUM; k++)
      f[k*VW +: VW] = {PIX_NUM{eb[k]}};
    return f;
  endfunction

  task automatic vec(input logic [7:0] b,
                     input logic st);
    frame_start_i = st;
    pix_valid_i   = 1'b1;
    pix_i         = {PIX_NUM{b}};
    tick();
    frame_start_i = 1'b0;
    pix_valid_i   = 1'b0;
  endtask

  task automatic start();
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
  endtask

  int v0;

  initial begin
    // 1: reset state and nominal frame
    #12;
    chk("rst_valid", 32'(frame_valid_o), 0);
    chk("rst_cnt", 32'(ch_cnt_o), 0);
    chk("rst_err", 32'(frame_err_o), 0);
    chk_frame("rst_frame", '0);
    rst_n = 1'b1;
    tick();
    start();
    for (int k = 0; k < CH_NUM; k++) begin
      eb[k] = 8'(k + 1);
      vec(eb[k], 1'b0);
      if (k == 0) chk("t1_cnt1", 32'(ch_cnt_o), 1);
      if (k == 30) chk("t1_cnt31", 32'(ch_cnt_o), 31);
      if (k < CH_NUM - 1) begin
        chk("t1_novalid", 32'(frame_valid_o), 0);
        repeat (17) tick();
      end
    end
    exp_f = build();
    chk("t1_valid", 32'(frame_valid_o), 1);
    chk("t1_cnt0", 32'(ch_cnt_o), 0);
    chk("t1_err", 32'(frame_err_o), 0);
    chk_frame("t1_frame", exp_f);
    f1 = exp_f;
    tick();
    chk("t1_pulse_low", 32'(frame_valid_o), 0);
    chk("t1_vcount", 32'(vcount), 1);

    // 2: back-to-back frame of -128
    start();
    for (int k = 0; k < CH_NUM; k++) begin
      eb[k] = 8'h80;
      vec(eb[k], 1'b0);
      if (k == 16) chk_frame("t2_hold_mid", f1);
      if (k == CH_NUM - 2) chk_frame("t2_hold_end", f1);
      tick();
    end
    chk("t2_vcount", 32'(vcount), 2);
    chk_frame("t2_frame", build());

    // 3: same-cycle start and valid
    eb[0] = 8'h7F;
    vec(eb[0], 1'b1);
    chk("t3_cnt1", 32'(ch_cnt_o), 1);
    for (int k = 1; k < CH_NUM; k++) begin
      eb[k] = 8'(k + 8'h20);
      vec(eb[k], 1'b0);
      if (k < CH_NUM - 1)
        chk("t3_novalid", 32'(frame_valid_o), 0);
    end
    chk("t3_valid", 32'(frame_valid_o), 1);
    chk_frame("t3_frame", build());
    chk("t3_err", 32'(frame_err_o), 0);
    tick();

    // 4: truncated frame then restart
    v0 = vcount;
    start();
    for (int k = 0; k < 10; k++) vec(8'hEE, 1'b0);
    chk("t4_err_pre", 32'(frame_err_o), 0);
    chk("t4_cnt10", 32'(ch_cnt_o), 10);
    start();
    chk("t4_err_set", 32'(frame_err_o), 1);
    chk("t4_cnt0", 32'(ch_cnt_o), 0);
    for (int k = 0; k < CH_NUM; k++) begin
      eb[k] = 8'h11;
      vec(eb[k], 1'b0);
    end
    chk("t4_valid", 32'(frame_valid_o), 1);
    tick();
    chk("t4_vcount", vcount - v0, 1);
    chk_frame("t4_frame", build());

    // 5: stray vector in IDLE after reset
    rst_n = 1'b0;
    #1;
    chk("t5_err_rst", 32'(frame_err_o), 0);
    rst_n = 1'b1;
    tick();
    v0 = vcount;
    vec(8'h55, 1'b0);
    chk("t5_err", 32'(frame_err_o), 1);
    chk("t5_cnt", 32'(ch_cnt_o), 0);
    chk("t5_valid", 32'(frame_valid_o), 0);
    chk_frame("t5_frame", '0);
    tick();
    chk("t5_vcount", vcount - v0, 0);

    // 6: reset mid-frame, then a clean frame
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    start();
    for (int k = 0; k < 20; k++) vec(8'h99, 1'b0);
    chk("t6_cnt20", 32'(ch_cnt_o), 20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_cnt_rst", 32'(ch_cnt_o), 0);
    chk("t6_valid_rst", 32'(frame_valid_o), 0);
    chk("t6_err_rst", 32'(frame_err_o), 0);
    chk_frame("t6_frame_rst", '0);
    tick();
    rst_n = 1'b1;
    tick();
    v0 = vcount;
    start();
    for (int k = 0; k < CH_NUM; k++) begin
      eb[k] = 8'(k + 8'h40);
      vec(eb[k], 1'b0);
    end
    chk("t6_valid", 32'(frame_valid_o), 1);
    chk_frame("t6_frame", build());
    tick();
    chk("t6_vcount", vcount - v0, 1);
    chk("t6_err", 32'(frame_err_o), 0);
    chk("no_double_pulse", 32'(dbl), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
